wav_trig_capture: RTL and testbench
===================================

Name: wav_trig_capture

Overview:
- Upstream feeder for the waveform display stage. Takes the 8-bit ADC sample stream, applies an edge trigger with pre-trigger history, and writes one 1024-sample frame per acquisition into the display RAM's write port.
- Reports the frame start address so the display reader can render the trigger point at a fixed horizontal position.
- Replaces the free-running sample/wait sequencer with triggered acquisition.

Parameters:
DEPTH, 1024, samples per frame; RAM window size (power of two)
AW, 11, RAM address width (matches display RAM)
PRE_TRIG, 256, samples kept before the trigger point (1..DEPTH-2)
AUTO_TO, 65536, valid samples in ARMED without a trigger before an auto-mode forced trigger

Ports:
clk  in  1  sample/write clock (same clock as the RAM write port)
rst  in  1  synchronous, active-high reset
adc_data  in  8  unsigned ADC sample, offset binary (127 = 0 V)
adc_valid  in  1  qualifies adc_data for one clk cycle
trig_level  in  8  trigger threshold
trig_edge  in  1  0 = rising, 1 = falling
trig_auto  in  1  1 = auto mode (forced trigger on timeout), 0 = normal mode
holdoff  in  32  clk cycles to wait after each frame before re-arming
stop  in  1  freeze acquisition at the next frame boundary
wr_data  out  8  RAM write data
wr_addr  out  AW  RAM write address
wr_en  out  1  RAM write enable
start_addr  out  AW  RAM address of the oldest sample of the last completed frame
frame_done  out  1  one-cycle pulse when a frame completes
triggered  out  1  1 = last frame came from a real edge; 0 = forced by auto timeout
busy  out  1  high in S_PRE, S_ARMED and S_POST

Behaviour:
- Reset (rst sampled high at a clk edge), outputs and internal state:
  - wr_en=0, wr_data=0, wr_addr=0, start_addr=0, frame_done=0, triggered=0.
  - Write pointer=0, state=S_IDLE, prev_valid=0.
  - Reset mid-frame abandons the frame; start_addr is not updated.
- Write path:
  - Every adc_valid sample accepted in S_PRE, S_ARMED or S_POST is written.
  - Registered outputs: wr_en=1, wr_data=adc_data, wr_addr=pointer, all appearing 1 cycle after adc_valid.
  - The pointer then increments modulo DEPTH (1023 -> 0) and persists across frames.
  - Bits of wr_addr above log2(DEPTH) are 0.
- Trigger event, evaluated only on a valid sample with prev_valid=1, where prev is the previous valid sample:
  - Rising: prev < trig_level and cur >= trig_level.
  - Falling: prev > trig_level and cur <= trig_level.
  - Comparisons are unsigned 8-bit.
  - prev and prev_valid update on every valid sample; prev_valid clears on entry to S_PRE.
- FSM:
  - S_IDLE: one cycle, then S_PRE.
  - S_PRE: write samples; pre_cnt counts them. After PRE_TRIG samples go to S_ARMED. Edges in S_PRE are ignored.
  - S_ARMED: keep writing circularly.
    - On a trigger-event sample: trig_addr = that sample's address, triggered_next=1, go to S_POST.
    - If trig_auto=1 and the timeout count reaches AUTO_TO: the current sample is treated as the trigger, triggered_next=0.
    - The timeout count clears on entry to S_ARMED.
  - S_POST: write DEPTH-PRE_TRIG-1 further samples, then S_DONE. The trigger sample counts as written in S_ARMED.
  - S_DONE: one cycle.
    - frame_done=1.
    - start_addr = (trig_addr - PRE_TRIG) mod DEPTH.
    - triggered = triggered_next.
    - Go to S_HOLD with the holdoff counter at 0.
  - S_HOLD: no writes; count clk cycles. When count >= holdoff and stop=0, go to S_PRE.
    - holdoff=0 gives one cycle in S_HOLD.
    - While stop=1 the FSM stays in S_HOLD, so the RAM and start_addr are frozen.
- stop asserted mid-frame does not abort; the frame completes, then the FSM freezes in S_HOLD.
- Trig_* inputs are sampled live. A change mid-frame affects only subsequent comparisons.
- A frame always holds exactly DEPTH consecutive valid samples, ending at start_addr-1 mod DEPTH.
- adc_valid gaps stall all sample counters but not the holdoff counter.

Decomposition:
- Shared package wav_pkg: state encoding (S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE, S_HOLD), DEPTH/AW defaults, trigger-edge constants.
- One natural sub-module, wav_edge_detect: holds prev/prev_valid and produces a one-cycle trig_hit from adc_data, adc_valid, trig_level and trig_edge.

Test Plan:
- Normal rising trigger: ramp 0..255 repeating, adc_valid every cycle, trig_level=128, PRE_TRIG=256 -> wr_en for exactly 1024 samples; trig_addr holds the sample 128; start_addr = trig_addr-256 mod 1024; triggered=1; one frame_done pulse.
- Falling edge: same ramp, trig_edge=1, trig_level=64 -> trigger on the first sample <=64 after one >64; the written value at trig_addr is <=64; triggered=1.
- Auto timeout: constant 100, trig_auto=1, AUTO_TO=16 -> frame completes with triggered=0. The same stimulus with trig_auto=0 -> no frame_done within 10000 cycles; busy=1.
- Stop and holdoff: holdoff=20, stop raised mid-S_POST -> frame finishes, frame_done pulses, wr_en stays 0 while stop=1. Dropping stop -> S_PRE is re-entered, with the first write no earlier than 21 cycles after frame_done.
- Wrap and gaps: adc_valid at 1/3 duty for 3 frames -> wr_addr wraps 1023->0 without skips; 1024 writes per frame.
- Reset mid-S_POST: rst high 1 cycle -> next cycle wr_en=0, wr_addr=0, start_addr unchanged from its reset value 0, no frame_done; acquisition restarts via S_IDLE.

Source files
------------

// File: rtl/wav_pkg.sv
// Shared definitions for the triggered waveform capture block.
// Holds the acquisition FSM state encoding, the default frame geometry
// and the trigger-edge selector constants.
package wav_pkg;

  // Default frame geometry and timeout; the top module exposes these as parameters.
  localparam int DEPTH_DEF    = 1024;
  localparam int AW_DEF       = 11;
  localparam int PRE_TRIG_DEF = 256;
  localparam int AUTO_TO_DEF  = 65536;

  // trig_edge encoding
  localparam logic EDGE_RISING  = 1'b0;
  localparam logic EDGE_FALLING = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

endpackage

// File: rtl/wav_edge_detect.sv
// Edge trigger detector for the ADC sample stream.
// Remembers the previous valid sample and flags, combinationally in the
// cycle of the current valid sample, whether the pair crosses trig_level
// in the selected direction.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   clear        drops the remembered sample (acquisition restart)
//   adc_data     current sample, unsigned 8-bit
//   adc_valid    qualifies adc_data for this cycle
//   trig_level   threshold, unsigned 8-bit
//   trig_edge    0 = rising, 1 = falling
//   trig_hit     crossing detected on this valid sample
module wav_edge_detect
  import wav_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [7:0] adc_data,
  input  logic       adc_valid,
  input  logic [7:0] trig_level,
  input  logic       trig_edge,
  output logic       trig_hit
);

  logic [7:0] prev;
  logic       prev_valid;

  // clear wins over a coincident sample: the sample arriving on the restart
  // cycle is not part of the new frame and must not seed the history.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= 8'd0;
      prev_valid <= 1'b0;
    end else if (clear) begin
      prev_valid <= 1'b0;
    end else if (adc_valid) begin
      prev       <= adc_data;
      prev_valid <= 1'b1;
    end
  end

  always_comb begin
    trig_hit = 1'b0;
    if (adc_valid && prev_valid) begin
      if (trig_edge == EDGE_FALLING)
        trig_hit = (prev > trig_level) && (adc_data <= trig_level);
      else
        trig_hit = (prev < trig_level) && (adc_data >= trig_level);
    end
  end

endmodule

// File: rtl/wav_trig_capture.sv
// Triggered acquisition front end for the waveform display.
// Writes the ADC stream circularly into the display RAM, keeps PRE_TRIG
// samples of history before an edge trigger (or an auto-mode forced
// trigger) and completes a DEPTH-sample frame, then reports where the
// oldest sample of that frame lives.
//
// Stream handshake: adc_valid qualifies adc_data for exactly one clk cycle;
// there is no backpressure, every valid sample is either written (S_PRE,
// S_ARMED, S_POST) or dropped (all other states).
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   adc_data/adc_valid  sample stream
//   trig_level/trig_edge/trig_auto  trigger setup, sampled live
//   holdoff             clk cycles to wait after a frame before re-arming
//   stop                freeze in S_HOLD at the next frame boundary
//   wr_data/wr_addr/wr_en  RAM write port (registered)
//   start_addr          oldest sample of the last completed frame
//   frame_done          one-cycle pulse per completed frame
//   triggered           1 = last frame from a real edge, 0 = auto timeout
//   busy                acquiring (S_PRE, S_ARMED, S_POST)
//   dbg_state           current FSM state (state_t encoding)
module wav_trig_capture
  import wav_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AW       = AW_DEF,
  parameter int PRE_TRIG = PRE_TRIG_DEF,
  parameter int AUTO_TO  = AUTO_TO_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    adc_data,
  input  logic          adc_valid,
  input  logic [7:0]    trig_level,
  input  logic          trig_edge,
  input  logic          trig_auto,
  input  logic [31:0]   holdoff,
  input  logic          stop,
  output logic [7:0]    wr_data,
  output logic [AW-1:0] wr_addr,
  output logic          wr_en,
  output logic [AW-1:0] start_addr,
  output logic          frame_done,
  output logic          triggered,
  output logic          busy,
  output logic [2:0]    dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(AUTO_TO + 1);

  // Terminal values: each counter stops at "count - 1" on the last sample.
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRE_TRIG - 1);
  localparam logic [PW-1:0] POST_LAST = PW'(DEPTH - PRE_TRIG - 2);
  localparam logic [TW-1:0] TO_LAST   = TW'(AUTO_TO - 1);

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] pre_cnt;
  logic [PW-1:0] post_cnt;
  logic [PW-1:0] trig_addr;
  logic [TW-1:0] to_cnt;
  logic [31:0]   hold_cnt;
  logic          triggered_next;
  logic          trig_hit;
  logic          enter_pre;
  logic          accept;

  assign enter_pre = (state == S_IDLE) ||
                     ((state == S_HOLD) && (hold_cnt >= holdoff) && !stop);

  assign accept = adc_valid &&
                  ((state == S_PRE) || (state == S_ARMED) || (state == S_POST));

  assign busy      = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
  assign dbg_state = state;

  wav_edge_detect u_edge (
    .clk        (clk),
    .rst        (rst),
    .clear      (enter_pre),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .trig_level (trig_level),
    .trig_edge  (trig_edge),
    .trig_hit   (trig_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      ptr            <= '0;
      pre_cnt        <= '0;
      post_cnt       <= '0;
      trig_addr      <= '0;
      to_cnt         <= '0;
      hold_cnt       <= 32'd0;
      triggered_next <= 1'b0;
      wr_en          <= 1'b0;
      wr_data        <= 8'd0;
      wr_addr        <= '0;
      start_addr     <= '0;
      frame_done     <= 1'b0;
      triggered      <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;

      // The pointer is never reset between frames; it only wraps.
      if (accept) begin
        wr_en   <= 1'b1;
        wr_data <= adc_data;
        wr_addr <= AW'(ptr);
        ptr     <= ptr + PW'(1);
      end

      case (state)
        S_IDLE: begin
          pre_cnt <= '0;
          state   <= S_PRE;
        end

        // Fill the history; edges here are deliberately ignored.
        S_PRE: begin
          if (adc_valid) begin
            if (pre_cnt == PRE_LAST) begin
              pre_cnt <= '0;
              to_cnt  <= '0;
              state   <= S_ARMED;
            end else begin
              pre_cnt <= pre_cnt + PW'(1);
            end
          end
        end

        // The trigger sample itself is written here, at ptr. The timeout
        // counter saturates so auto mode can be enabled while waiting.
        S_ARMED: begin
          if (adc_valid) begin
            if (trig_hit) begin
              trig_addr      <= ptr;
              triggered_next <= 1'b1;
              post_cnt       <= '0;
              state          <= S_POST;
            end else if (trig_auto && (to_cnt == TO_LAST)) begin
              trig_addr      <= ptr;
              triggered_next <= 1'b0;
              post_cnt       <= '0;
              state          <= S_POST;
            end else if (to_cnt != TO_LAST) begin
              to_cnt <= to_cnt + TW'(1);
            end
          end
        end

        S_POST: begin
          if (adc_valid) begin
            if (post_cnt == POST_LAST)
              state <= S_DONE;
            else
              post_cnt <= post_cnt + PW'(1);
          end
        end

        S_DONE: begin
          frame_done <= 1'b1;
          start_addr <= AW'(PW'(trig_addr - PW'(PRE_TRIG)));
          triggered  <= triggered_next;
          hold_cnt   <= 32'd0;
          state      <= S_HOLD;
        end

        // Holdoff counts clk cycles, not samples; the count saturates at
        // holdoff so a long stop cannot wrap it.
        S_HOLD: begin
          if (enter_pre) begin
            pre_cnt <= '0;
            state   <= S_PRE;
          end else if (hold_cnt < holdoff) begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wav_trig_capture.sv
// Directed bench for wav_trig_capture (DEPTH=1024, PRE_TRIG=256, AUTO_TO=16).
module tb_wav_trig_capture;
  import wav_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  adc_data;
  logic        adc_valid;
  logic [7:0]  trig_level;
  logic        trig_edge;
  logic        trig_auto;
  logic [31:0] holdoff;
  logic        stop;
  logic [7:0]  wr_data;
  logic [10:0] wr_addr;
  logic        wr_en;
  logic [10:0] start_addr;
  logic        frame_done;
  logic        triggered;
  logic        busy;
  logic [2:0]  dbg_state;

  wav_trig_capture #(
    .DEPTH    (1024),
    .AW       (11),
    .PRE_TRIG (256),
    .AUTO_TO  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .trig_level (trig_level),
    .trig_edge  (trig_edge),
    .trig_auto  (trig_auto),
    .holdoff    (holdoff),
    .stop       (stop),
    .wr_data    (wr_data),
    .wr_addr    (wr_addr),
    .wr_en      (wr_en),
    .start_addr (start_addr),
    .frame_done (frame_done),
    .triggered  (triggered),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- sample generator ----------------
  logic       gen_on     = 1'b0;
  logic       const_mode = 1'b0;
  logic [7:0] const_val  = 8'd100;
  logic [7:0] ramp_v     = 8'd0;
  int         duty       = 1;
  int         phase      = 0;

  // ---------------- RAM model / monitor ----------------
  logic [7:0] mem [0:1023];
  logic [7:0] exp_q [$];
  int         wr_cnt = 0, fd_cnt = 0, skip_cnt = 0, wrap_cnt = 0;
  int         cyc = 0, fd_cyc = 0, gap = 0;
  logic [9:0] last_addr = 10'd0;
  bit         have_last = 0, gap_pending = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      have_last   = 0;
      gap_pending = 0;
    end else begin
      if (wr_en) begin
        wr_cnt++;
        mem[wr_addr[9:0]] = wr_data;
        if (wr_addr[10] !== 1'b0) skip_cnt++;
        if (have_last && (wr_addr[9:0] != 10'(last_addr + 10'd1))) skip_cnt++;
        if (have_last && (last_addr == 10'd1023) && (wr_addr[9:0] == 10'd0)) wrap_cnt++;
        last_addr = wr_addr[9:0];
        have_last = 1;
        if (gap_pending) begin
          gap         = cyc - fd_cyc;
          gap_pending = 0;
        end
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc      = cyc;
        gap_pending = 1;
      end
    end
  end

  // ---------------- checking / driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clk cycle: drive after the rising edge, return after the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (gen_on && (phase == 0)) begin
      adc_valid = 1'b1;
      adc_data  = const_mode ? const_val : ramp_v;
      if (!const_mode) ramp_v = ramp_v + 8'd1;
    end else begin
      adc_valid = 1'b0;
    end
    phase = (phase + 1 >= duty) ? 0 : phase + 1;
    @(negedge clk);
    #1;
  endtask

  task automatic run_frame(input int budget, input string tag);
    int fd0;
    bit got;
    fd0 = fd_cnt;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (fd_cnt != fd0) begin
        got = 1;
        break;
      end
    end
    check({tag, "_frame_seen"}, 32'(got), 32'd1);
  endtask

  task automatic wait_state(input state_t s, input int budget, input string tag);
    bit got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (dbg_state == s) begin
        got = 1;
        break;
      end
    end
    check({tag, "_reached"}, 32'(got), 32'd1);
  endtask

  // The frame must be a contiguous ramp starting at 'first' at start_addr
  // and the last write must sit just before start_addr.
  task automatic check_frame_ramp(input logic [7:0] first, input string tag);
    logic [9:0] s;
    logic [7:0] e;
    int         mism;
    s    = start_addr[9:0];
    mism = 0;
    for (int k = 0; k < 1024; k++) exp_q.push_back(8'(32'(first) + k));
    for (int k = 0; k < 1024; k++) begin
      e = exp_q.pop_front();
      if (mem[10'(32'(s) + k)] !== e) mism++;
    end
    check({tag, "_content"}, 32'(mism), 32'd0);
    check({tag, "_end_addr"}, 32'(last_addr), 32'(10'(s - 10'd1)));
  endtask

  // ---------------- directed sequence ----------------
  int w0, f0, sk0, wp0;

  initial begin
    rst        = 1'b1;
    adc_data   = 8'd0;
    adc_valid  = 1'b0;
    trig_level = 8'd128;
    trig_edge  = EDGE_RISING;
    trig_auto  = 1'b0;
    holdoff    = 32'd0;
    stop       = 1'b1;

    // Reset state
    repeat (3) step();
    check("rst_wr_en",      32'(wr_en),      32'd0);
    check("rst_wr_addr",    32'(wr_addr),    32'd0);
    check("rst_wr_data",    32'(wr_data),    32'd0);
    check("rst_start_addr", 32'(start_addr), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_triggered",  32'(triggered),  32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_state",      32'(dbg_state),  32'(S_IDLE));
    rst = 1'b0;

    // T1: rising edge at 128, ramp starting at 0 on the first S_PRE cycle.
    // PRE 0..255 (addr 0..255), ARMED 0..128 (addr 256..384), trigger at 384,
    // POST 767 samples -> 1152 writes, start_addr = 128.
    wait_state(S_PRE, 10, "t1_pre");
    gen_on = 1'b1; ramp_v = 8'd0; duty = 1; phase = 0;
    w0 = wr_cnt;
    run_frame(3000, "t1");
    check("t1_writes",     32'(wr_cnt - w0), 32'd1152);
    check("t1_start_addr", 32'(start_addr),  32'd128);
    check("t1_triggered",  32'(triggered),   32'd1);
    check("t1_fd_high",    32'(frame_done),  32'd1);
    check_frame_ramp(8'd128, "t1");
    step();
    check("t1_fd_pulse",   32'(frame_done),  32'd0);
    repeat (5) step();
    check("t1_frozen",     32'(dbg_state),   32'(S_HOLD));

    // T2: falling edge at 64 on a rising ramp -> trigger on the 255->0 wrap.
    trig_edge = EDGE_FALLING; trig_level = 8'd64; stop = 1'b0;
    wait_state(S_PRE, 20, "t2_pre");
    stop = 1'b1;
    run_frame(3000, "t2");
    check("t2_triggered", 32'(triggered), 32'd1);
    check_frame_ramp(8'd0, "t2");

    // T3a: constant input, auto off -> waits in ARMED indefinitely.
    trig_edge = EDGE_RISING; trig_level = 8'd128;
    const_mode = 1'b1; const_val = 8'd100; trig_auto = 1'b0; stop = 1'b0;
    wait_state(S_PRE, 20, "t3a_pre");
    stop = 1'b1;
    f0 = fd_cnt;
    repeat (10000) step();
    check("t3a_no_frame", 32'(fd_cnt - f0), 32'd0);
    check("t3a_busy",     32'(busy),        32'd1);
    check("t3a_state",    32'(dbg_state),   32'(S_ARMED));

    // T3b: enabling auto with the timeout already expired forces a trigger.
    trig_auto = 1'b1;
    run_frame(2000, "t3b");
    check("t3b_triggered", 32'(triggered), 32'd0);

    // T3c: fresh auto frame: 256 + 16 + 767 = 1039 writes.
    w0 = wr_cnt;
    stop = 1'b0;
    wait_state(S_PRE, 20, "t3c_pre");
    stop = 1'b1;
    run_frame(2000, "t3c");
    check("t3c_writes",    32'(wr_cnt - w0),                32'd1039);
    check("t3c_triggered", 32'(triggered),                  32'd0);
    check("t3c_data",      32'(mem[start_addr[9:0]]),       32'd100);

    // T4a: stop raised mid-POST, holdoff 20 -> frame completes, then frozen.
    holdoff = 32'd20; stop = 1'b0;
    wait_state(S_PRE, 40, "t4_pre");
    wait_state(S_POST, 2000, "t4_post");
    stop = 1'b1;
    f0 = fd_cnt;
    run_frame(2000, "t4a");
    w0 = wr_cnt;
    repeat (50) step();
    check("t4a_one_frame", 32'(fd_cnt - f0), 32'd1);
    check("t4a_no_writes", 32'(wr_cnt - w0), 32'd0);
    check("t4a_state",     32'(dbg_state),   32'(S_HOLD));
    check("t4a_busy",      32'(busy),        32'd0);

    // T4b: free-running frame; first write after frame_done lands 22 cycles
    // later (21 HOLD cycles incl. count 0..20, one S_PRE cycle to register).
    stop = 1'b0;
    run_frame(2000, "t4b");
    for (int i = 0; i < 100; i++) begin
      if (!gap_pending) break;
      step();
    end
    check("t4b_gap_seen", 32'(gap_pending), 32'd0);
    check("t4b_gap",      32'(gap),         32'd22);
    stop = 1'b1;
    run_frame(2000, "t4c");
    holdoff = 32'd0;

    // T5: 1/3 duty ramp, three real-edge frames, no address skips.
    const_mode = 1'b0; trig_auto = 1'b0; trig_edge = EDGE_RISING;
    trig_level = 8'd128; duty = 3; phase = 0;
    sk0 = skip_cnt; wp0 = wrap_cnt; w0 = wr_cnt;
    stop = 1'b0;
    for (int f = 0; f < 3; f++) begin
      run_frame(6000, "t5");
      check("t5_triggered", 32'(triggered), 32'd1);
      check_frame_ramp(8'd128, "t5");
      if (f == 2) stop = 1'b1;
    end
    check("t5_no_skip",    32'(skip_cnt - sk0),            32'd0);
    check("t5_wraps",      32'((wrap_cnt - wp0) >= 3),     32'd1);
    check("t5_min_writes", 32'((wr_cnt - w0) >= 3072),     32'd1);
    duty = 1; phase = 0;

    // T6: reset mid-POST abandons the frame; restart behaves like T1.
    stop = 1'b0;
    wait_state(S_PRE, 20, "t6_pre");
    stop = 1'b1;
    wait_state(S_POST, 3000, "t6_post");
    f0 = fd_cnt;
    gen_on = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_wr_en",      32'(wr_en),      32'd0);
    check("t6_wr_addr",    32'(wr_addr),    32'd0);
    check("t6_start_addr", 32'(start_addr), 32'd0);
    check("t6_frame_done", 32'(frame_done), 32'd0);
    check("t6_state",      32'(dbg_state),  32'(S_IDLE));
    step();
    check("t6_restart",    32'(dbg_state),  32'(S_PRE));
    gen_on = 1'b1; ramp_v = 8'd0; phase = 0;
    w0 = wr_cnt;
    run_frame(3000, "t6");
    check("t6_one_frame",  32'(fd_cnt - f0), 32'd1);
    check("t6_writes",     32'(wr_cnt - w0), 32'd1152);
    check("t6_start",      32'(start_addr),  32'd128);
    check("t6_triggered",  32'(triggered),   32'd1);
    check_frame_ramp(8'd128, "t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
